// File: rtl/hdmi_pattern_gen.sv
// Video timing generator (h/v counters, syncs, data enable) with four selectable
// test patterns: solid colour, colour bars, checkerboard and a moving white bar.
module hdmi_pattern_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned CHK_LOG2 = 5,
    parameter int unsigned BAR_W    = 16
) (
    input  logic        clk_low,
    input  logic        reset_n,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned SEG_W   = H_ACTIVE / 8;
    localparam int unsigned SW      = (SEG_W > 1) ? $clog2(SEG_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [SW-1:0] SEG_LAST = SW'(SEG_W - 1);
    localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE - 1);

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_MOVING  = 2'd3
    } mode_e;

    // Timing and pattern state
    logic          r_run;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [SW-1:0] r_seg_cnt;
    logic [2:0]    r_seg_idx;
    logic [HW-1:0] r_bar_pos;
    logic [15:0]   r_frame_cnt;
    mode_e         r_mode;
    logic [23:0]   r_solid;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_origin;
    logic          w_frame_wrap;
    mode_e         w_mode;
    logic [23:0]   w_solid;
    logic [31:0]   w_h32;
    logic [31:0]   w_v32;
    logic [31:0]   w_bar_lo;
    logic [31:0]   w_bar_hi;
    logic          w_de;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_chk;
    logic          w_in_bar;
    logic [23:0]   w_rgb;

    assign w_h_last     = (r_h_cnt == H_LAST);
    assign w_v_last     = (r_v_cnt == V_LAST);
    assign w_origin     = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_frame_wrap = w_h_last && w_v_last;

    // The frame's first pixel already uses the value being latched at (0,0).
    assign w_mode  = w_origin ? mode_e'(mode) : r_mode;
    assign w_solid = w_origin ? solid_rgb     : r_solid;

    assign w_h32    = 32'(r_h_cnt);
    assign w_v32    = 32'(r_v_cnt);
    assign w_bar_lo = 32'(r_bar_pos);
    assign w_bar_hi = 32'(r_bar_pos) + BAR_W;

    assign w_de     = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
    assign w_hs_act = (w_h32 >= H_ACTIVE + H_FP) && (w_h32 < H_ACTIVE + H_FP + H_SYNC);
    assign w_vs_act = (w_v32 >= V_ACTIVE + V_FP) && (w_v32 < V_ACTIVE + V_FP + V_SYNC);
    assign w_chk    = w_h32[CHK_LOG2] ^ w_v32[CHK_LOG2];
    // Clipping of the bar at H_ACTIVE comes for free from the de gating below.
    assign w_in_bar = (w_h32 >= w_bar_lo) && (w_h32 < w_bar_hi);

    // r_run holds the counters at (0,0) for one edge after reset release.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n) begin
            r_run       <= 1'b0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_seg_cnt   <= '0;
            r_seg_idx   <= '0;
            r_bar_pos   <= '0;
            r_frame_cnt <= '0;
            r_mode      <= MODE_SOLID;
            r_solid     <= '0;
        end else if (!r_run) begin
            r_run <= 1'b1;
        end else begin
            if (w_origin) begin
                r_mode  <= mode_e'(mode);
                r_solid <= solid_rgb;
            end

            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end

            // Segment counter tracks h_cnt so the bar index needs no divider.
            if (w_h_last) begin
                r_seg_cnt <= '0;
                r_seg_idx <= '0;
            end else if (r_seg_cnt == SEG_LAST) begin
                r_seg_cnt <= '0;
                r_seg_idx <= r_seg_idx + 3'd1;
            end else begin
                r_seg_cnt <= r_seg_cnt + 1'b1;
            end

            if (w_frame_wrap) begin
                r_bar_pos   <= (r_bar_pos == BAR_LAST) ? '0 : r_bar_pos + 1'b1;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // NOTE: the colour defaults to black before the case so no path leaves
    // w_rgb unassigned, which would otherwise infer a latch.
    always_comb begin
        w_rgb = 24'h000000;
        if (w_de) begin
            case (w_mode)
                MODE_SOLID:   w_rgb = w_solid;
                MODE_BARS:    w_rgb = {{8{~r_seg_idx[1]}}, {8{~r_seg_idx[2]}}, {8{~r_seg_idx[0]}}};
                MODE_CHECKER: w_rgb = w_chk ? 24'h000000 : 24'hFFFFFF;
                MODE_MOVING:  w_rgb = w_in_bar ? 24'hFFFFFF : 24'h000000;
                default:      w_rgb = 24'h000000;
            endcase
        end
    end

    always_ff @(posedge clk_low or negedge reset_n) begin
        if (!reset_n) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else if (r_run) begin
            red         <= w_rgb[23:16];
            green       <= w_rgb[15:8];
            blue        <= w_rgb[7:0];
            hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            de          <= w_de;
            frame_start <= w_origin;
        end
    end

    assign frame_cnt = r_frame_cnt;

endmodule
